tl_cfg_driver: RTL and testbench

TL_CFG_DRIVER -- requirements
Module: tl_cfg_driver

---
 rtl/tl_cfg_driver.sv | 53 +++++
 tb/tb_tl_cfg_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tl_cfg_driver.sv
// Config-bus driver: walks 16 shadow registers onto tl_cfg_add/tl_cfg_ctl,
// holding each address for HOLD_CYCLES clocks, and forwards a registered status word.
module tl_cfg_driver #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr_valid,
    output logic        cfg_wr_ready,
    input  logic [3:0]  cfg_wr_addr,
    input  logic [31:0] cfg_wr_data,
    input  logic [52:0] sts_in,
    output logic [3:0]  tl_cfg_add,
    output logic [31:0] tl_cfg_ctl,
    output logic [52:0] tl_cfg_sts,
    output logic        round_done
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [31:0] regs [16];
    logic [7:0]  hold_cnt;
    logic        window_end;
    logic [3:0]  next_add;

    assign window_end   = (hold_cnt == HOLD_LAST);
    assign next_add     = tl_cfg_add + 4'd1;
    assign cfg_wr_ready = ~reset;
    assign round_done   = ~reset & window_end & (tl_cfg_add == 4'hF);

    // tl_cfg_add is the address counter itself, so address and data always
    // switch on the same edge. The snapshot reads regs before any same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            hold_cnt   <= '0;
            tl_cfg_add <= '0;
            tl_cfg_ctl <= '0;
            tl_cfg_sts <= '0;
        end else begin
            tl_cfg_sts <= sts_in;
            if (cfg_wr_valid) regs[cfg_wr_addr] <= cfg_wr_data;
            if (window_end) begin
                hold_cnt   <= '0;
                tl_cfg_add <= next_add;
                tl_cfg_ctl <= regs[next_add];
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tl_cfg_driver.sv
// Directed bench for tl_cfg_driver with HOLD_CYCLES=8; cycle 0 is the first
// cycle after reset falls.
module tb_tl_cfg_driver;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic [3:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic [52:0] sts_in;
    logic [3:0]  tl_cfg_add;
    logic [31:0] tl_cfg_ctl;
    logic [52:0] tl_cfg_sts;
    logic        round_done;

    int          checks   = 0;
    int          failures = 0;
    logic [52:0] prev_sts = '0;

    tl_cfg_driver #(.HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .sts_in       (sts_in),
        .tl_cfg_add   (tl_cfg_add),
        .tl_cfg_ctl   (tl_cfg_ctl),
        .tl_cfg_sts   (tl_cfg_sts),
        .round_done   (round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        cfg_wr_valid = 1'b0;
        cfg_wr_addr  = '0;
        cfg_wr_data  = '0;
        sts_in       = 53'h123;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_add",   64'(tl_cfg_add),   64'h0);
        chk("rst_ctl",   64'(tl_cfg_ctl),   64'h0);
        chk("rst_sts",   64'(tl_cfg_sts),   64'h0);
        chk("rst_done",  64'(round_done),   64'h0);
        chk("rst_ready", 64'(cfg_wr_ready), 64'h0);
        @(posedge clk); #1;
        reset    = 1'b0;
        prev_sts = '0;
    endtask

    // One clock cycle c: drive inputs, check outputs at the falling edge.
    task automatic run_cycle(input int c, input logic [31:0] exp_ctl,
                             input logic wv, input logic [3:0] wa,
                             input logic [31:0] wd, input logic [52:0] sv);
        cfg_wr_valid = wv;
        cfg_wr_addr  = wa;
        cfg_wr_data  = wd;
        sts_in       = sv;
        @(negedge clk);
        chk($sformatf("add@%0d", c),   64'(tl_cfg_add),   64'((c / HOLD) % 16));
        chk($sformatf("ctl@%0d", c),   64'(tl_cfg_ctl),   64'(exp_ctl));
        chk($sformatf("done@%0d", c),  64'(round_done),   64'((c % 128) == 127));
        chk($sformatf("ready@%0d", c), 64'(cfg_wr_ready), 64'h1);
        chk($sformatf("sts@%0d", c),   64'(tl_cfg_sts),   64'(prev_sts));
        prev_sts = sv;
        @(posedge clk); #1;
        cfg_wr_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_a(input int c);
        int w, r;
        w = (c / HOLD) % 16;
        r = c / 128;
        if (r == 0 && w == 15) return 32'h0000_1A28;
        if (r == 1 && w == 3)  return 32'hDEAD_BEEF;
        if (r == 1 && w == 4)  return 32'h0000_0055;
        return 32'h0;
    endfunction

    initial begin
        logic        wv;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [52:0] sv;

        // Phase A: idle round plus three writes, including a window-end collision.
        do_reset();
        for (int c = 0; c < 176; c++) begin
            wv = 1'b0; wa = 4'h0; wd = 32'h0;
            sv = 53'(c);
            if (c == 10) begin wv = 1'b1; wa = 4'hF; wd = 32'h0000_1A28; end
            if (c == 26) begin wv = 1'b1; wa = 4'h3; wd = 32'hDEAD_BEEF; end
            if (c == 31) begin wv = 1'b1; wa = 4'h4; wd = 32'h0000_0055; end
            if (c == 60) sv = 53'h1F_FFFF_FFFF_FFFF;
            run_cycle(c, exp_a(c), wv, wa, wd, sv);
            if (c == 120) begin
                chk("ctl_hi_field", 64'(tl_cfg_ctl[12:5]), 64'hD1);
                chk("ctl_lo_field", 64'(tl_cfg_ctl[4:0]),  64'h08);
            end
        end

        // Phase B: writes to regs 2 and 7, then a reset pulse mid-window at cycle 50.
        do_reset();
        for (int c = 0; c < 50; c++) begin
            wv = 1'b0; wa = 4'h0; wd = 32'h0;
            if (c == 3) begin wv = 1'b1; wa = 4'h2; wd = 32'h2222_2222; end
            if (c == 4) begin wv = 1'b1; wa = 4'h7; wd = 32'h7777_7777; end
            run_cycle(c, (c >= 16 && c < 24) ? 32'h2222_2222 : 32'h0,
                      wv, wa, wd, 53'(c + 1000));
        end
        reset  = 1'b1;
        sts_in = 53'h55;
        @(negedge clk);
        chk("midrst_ready", 64'(cfg_wr_ready), 64'h0);
        chk("midrst_done",  64'(round_done),   64'h0);
        @(posedge clk); #1;
        reset    = 1'b0;
        prev_sts = '0;
        for (int c = 0; c < 128; c++) begin
            run_cycle(c, 32'h0, 1'b0, 4'h0, 32'h0, 53'(c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
